// File: rtl/alu_seq.sv
// alu_seq: sequencer that runs one 8-bit op at a time on an external shared ALU
// Ports:
//    clk, rst                       clock, asynchronous active-high reset
//    req_valid/req_ready            request handshake; req_op, req_a, req_b captured on accept
//    resp_valid/resp_ready          response handshake; res_lo, res_hi, res_flag, res_err held in DONE
//    alu_a, alu_b, alu_ctrl         drive to the shared ALU (zero outside EXEC/MUL)
//    alu_out, alu_cout              results returned by the shared ALU
// Macro ALU_SEQ_MUL_EN enables op 6 (8x8 shift-add multiply); without it op 6 is illegal.
module alu_seq (
   input  logic       clk,
   input  logic       rst,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic [2:0] req_op,
   input  logic [7:0] req_a,
   input  logic [7:0] req_b,
   output logic       resp_valid,
   input  logic       resp_ready,
   output logic [7:0] res_lo,
   output logic [7:0] res_hi,
   output logic       res_flag,
   output logic       res_err,
   output logic [7:0] alu_a,
   output logic [7:0] alu_b,
   output logic [2:0] alu_ctrl,
   input  logic [7:0] alu_out,
   input  logic       alu_cout
);
   typedef enum logic [1:0] {
      IDLE, EXEC, DONE
`ifdef ALU_SEQ_MUL_EN
      , MUL
`endif
   } state_t;
   state_t     state_q;
   logic [2:0] op_q;
   logic [7:0] a_q, b_q, res_lo_q, res_hi_q;
   logic       res_flag_q, res_err_q, resp_valid_q, illegal;
`ifdef ALU_SEQ_MUL_EN
   logic [7:0]  hi_q, lo_q;
   logic [2:0]  cnt_q;
   logic [15:0] mul_d;
   // {hi,lo} <= {cout,out,lo} >> 1, keeping the low 16 bits
   assign mul_d = {alu_cout, alu_out, lo_q[7:1]};
   assign illegal = req_op == 3'd7;
`else
   assign illegal = req_op[2:1] == 2'b11;
`endif
   assign req_ready = state_q == IDLE && !rst;
   assign resp_valid = resp_valid_q;
   assign res_lo = res_lo_q;
   assign res_hi = res_hi_q;
   assign res_flag = res_flag_q;
   assign res_err = res_err_q;
   always_comb begin
      alu_a = '0;
      alu_b = '0;
      alu_ctrl = '0;
      if (state_q == EXEC) begin
         alu_a = a_q;
         alu_b = b_q;
         alu_ctrl = op_q;
      end
`ifdef ALU_SEQ_MUL_EN
      if (state_q == MUL) begin
         alu_a = hi_q;
         alu_b = lo_q[0] ? a_q : '0;
      end
`endif
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         op_q <= '0;
         a_q <= '0;
         b_q <= '0;
         res_lo_q <= '0;
         res_hi_q <= '0;
         res_flag_q <= 1'b0;
         res_err_q <= 1'b0;
         resp_valid_q <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
         hi_q <= '0;
         lo_q <= '0;
         cnt_q <= '0;
`endif
      end else begin
         case (state_q)
            IDLE: if (req_valid) begin
               op_q <= req_op;
               a_q <= req_a;
               b_q <= req_b;
               if (illegal) begin
                  res_lo_q <= '0;
                  res_hi_q <= '0;
                  res_flag_q <= 1'b0;
                  res_err_q <= 1'b1;
                  resp_valid_q <= 1'b1;
                  state_q <= DONE;
               end
`ifdef ALU_SEQ_MUL_EN
               else if (req_op == 3'd6) begin
                  hi_q <= '0;
                  lo_q <= req_b;
                  cnt_q <= '0;
                  state_q <= MUL;
               end
`endif
               else state_q <= EXEC;
            end
            EXEC: begin
               res_lo_q <= alu_out;
               res_hi_q <= '0;
               // carry only meaningful for ADD/SUB (SUB: 1 = no borrow)
               res_flag_q <= op_q[2:1] == 2'b00 && alu_cout;
               res_err_q <= 1'b0;
               resp_valid_q <= 1'b1;
               state_q <= DONE;
            end
`ifdef ALU_SEQ_MUL_EN
            MUL: begin
               hi_q <= mul_d[15:8];
               lo_q <= mul_d[7:0];
               cnt_q <= cnt_q + 3'd1;
               if (cnt_q == 3'd7) begin
                  res_hi_q <= mul_d[15:8];
                  res_lo_q <= mul_d[7:0];
                  res_flag_q <= |mul_d[15:8];
                  res_err_q <= 1'b0;
                  resp_valid_q <= 1'b1;
                  state_q <= DONE;
               end
            end
`endif
            DONE: if (resp_ready) begin
               resp_valid_q <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed bench for alu_seq with a reference model and per-cycle compare
module tb_alu_seq;
   logic       clk = 1'b0, rst = 1'b1, req_valid = 1'b0, resp_ready = 1'b0;
   logic [2:0] req_op = '0;
   logic [7:0] req_a = '0, req_b = '0;
   logic       req_ready, resp_valid, res_flag, res_err, alu_cout;
   logic [7:0] res_lo, res_hi, alu_a, alu_b, alu_out;
   logic [2:0] alu_ctrl;
   int         n_chk = 0, n_err = 0, ecnt = 0;
   alu_seq dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_op(req_op), .req_a(req_a), .req_b(req_b),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .res_lo(res_lo), .res_hi(res_hi), .res_flag(res_flag), .res_err(res_err),
      .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
      .alu_out(alu_out), .alu_cout(alu_cout)
   );
   always #5 clk = ~clk;
   always @(posedge clk) ecnt <= ecnt + 1;
   // shared ALU attached to the sequencer
   always_comb begin
      {alu_cout, alu_out} = 9'd0;
      case (alu_ctrl)
         3'd0: {alu_cout, alu_out} = {1'b0, alu_a} + {1'b0, alu_b};
         3'd1: {alu_cout, alu_out} = {1'b0, alu_a} + {1'b0, ~alu_b} + 9'd1;
         3'd2: alu_out = alu_a >> alu_b[2:0];
         3'd3: alu_out = ~(alu_a | alu_b);
         3'd4: alu_out = ~(alu_a & alu_b);
         3'd5: alu_out = alu_a << alu_b[2:0];
         default: {alu_cout, alu_out} = 9'd0;
      endcase
   end
   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, want %0d at %0t", nm, act, exp, $time);
      end
   endtask
   // expected {err, flag, hi, lo} from plain arithmetic
   function automatic logic [17:0] ref_res(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
      int ia, ib, r;
      logic [7:0] lo, hi;
      logic fl, er;
      ia = a; ib = b; r = 0; lo = 0; hi = 0; fl = 0; er = 0;
      case (op)
         3'd0: begin r = ia + ib; lo = r[7:0]; fl = r > 255; end
         3'd1: begin r = ia - ib; lo = r[7:0]; fl = ia >= ib; end
         3'd2: lo = 8'(ia >> (ib % 8));
         3'd3: lo = ~(a | b);
         3'd4: lo = ~(a & b);
         3'd5: lo = 8'(ia << (ib % 8));
`ifdef ALU_SEQ_MUL_EN
         3'd6: begin r = ia * ib; lo = r[7:0]; hi = r[15:8]; fl = hi != 0; end
`endif
         default: er = 1;
      endcase
      return {er, fl, hi, lo};
   endfunction
   // edges from the edge after which the request is driven to resp_valid
   function automatic int ref_lat(input logic [2:0] op);
`ifdef ALU_SEQ_MUL_EN
      return op == 3'd7 ? 1 : op == 3'd6 ? 9 : 2;
`else
      return op >= 3'd6 ? 1 : 2;
`endif
   endfunction
   int          m_st = 0, m_left = 0;
   bit          m_res = 1'b1;
   logic [17:0] m_exp = '0;
   logic [2:0]  m_op = '0;
   logic [7:0]  m_a = '0, m_b = '0;
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_st <= 0;
         m_left <= 0;
         m_res <= 1'b1;
         m_exp <= '0;
      end else if (m_st == 0) begin
         if (req_valid) begin
            m_op <= req_op;
            m_a <= req_a;
            m_b <= req_b;
            m_exp <= ref_res(req_op, req_a, req_b);
            m_left <= ref_lat(req_op) - 2;
            m_st <= ref_lat(req_op) == 1 ? 2 : 1;
            m_res <= ref_lat(req_op) == 1;
         end
      end else if (m_st == 1) begin
         if (m_left == 0) begin
            m_st <= 2;
            m_res <= 1'b1;
         end else m_left <= m_left - 1;
      end else if (resp_ready) begin
         m_st <= 0;
         m_res <= 1'b0;
      end
   end
   always @(negedge clk) begin
      chk("req_ready", req_ready, !rst && m_st == 0);
      chk("resp_valid", resp_valid, m_st == 2);
      if (m_res) begin
         chk("res_lo", res_lo, m_exp[7:0]);
         chk("res_hi", res_hi, m_exp[15:8]);
         chk("res_flag", res_flag, m_exp[16]);
         chk("res_err", res_err, m_exp[17]);
      end
      if (m_st != 1) begin
         chk("alu_idle", {alu_ctrl, alu_a, alu_b}, 0);
      end else if (m_op < 3'd6) begin
         chk("alu_a", alu_a, m_a);
         chk("alu_b", alu_b, m_b);
         chk("alu_ctrl", alu_ctrl, m_op);
      end
   end
   task automatic run(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] elo, input logic [7:0] ehi, input logic efl, input logic eer,
                      input int elat, input int hold, input bit junk);
      int e0;
      bit got;
      req_op = op; req_a = a; req_b = b; req_valid = 1'b1;
      e0 = ecnt;
      @(posedge clk);
      #1;
      req_valid = junk;
      if (junk) begin
         req_op = 3'd7; req_a = 8'hAA; req_b = 8'h55;
      end
      got = 1'b0;
      for (int i = 0; i < 30 && !got; i++) begin
         @(negedge clk);
         got = resp_valid;
      end
      chk("timeout", got, 1);
      chk("latency", ecnt - e0, elat);
      chk("lit_lo", res_lo, elo);
      chk("lit_hi", res_hi, ehi);
      chk("lit_flag", res_flag, efl);
      chk("lit_err", res_err, eer);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk("hold_lo", res_lo, elo);
         chk("hold_ready", req_ready, 0);
         chk("hold_valid", resp_valid, 1);
      end
      req_valid = 1'b0;
      resp_ready = 1'b1;
      @(posedge clk);
      #1;
      resp_ready = 1'b0;
   endtask
   initial begin
      repeat (2) @(negedge clk);
      chk("rst_ready", req_ready, 0);
      chk("rst_valid", resp_valid, 0);
      chk("rst_lo", res_lo, 0);
      @(posedge clk);
      #2 rst = 1'b0;
      @(posedge clk);
      #1;
      run(3'd0, 8'd200, 8'd100, 8'd44, 8'd0, 1'b1, 1'b0, 2, 0, 1'b0);
      run(3'd1, 8'd5, 8'd7, 8'hFE, 8'd0, 1'b0, 1'b0, 2, 0, 1'b0);
      run(3'd5, 8'h81, 8'd3, 8'h08, 8'd0, 1'b0, 1'b0, 2, 0, 1'b0);
      run(3'd2, 8'hF0, 8'h0C, 8'h0F, 8'd0, 1'b0, 1'b0, 2, 0, 1'b0);
      run(3'd3, 8'h0F, 8'h30, 8'hC0, 8'd0, 1'b0, 1'b0, 2, 0, 1'b0);
      run(3'd4, 8'hFF, 8'h0F, 8'hF0, 8'd0, 1'b0, 1'b0, 2, 0, 1'b0);
      run(3'd1, 8'd7, 8'd5, 8'd2, 8'd0, 1'b1, 1'b0, 2, 0, 1'b0);
      run(3'd7, 8'h12, 8'h34, 8'd0, 8'd0, 1'b0, 1'b1, 1, 0, 1'b0);
`ifdef ALU_SEQ_MUL_EN
      run(3'd6, 8'hFF, 8'hFF, 8'h01, 8'hFE, 1'b1, 1'b0, 9, 0, 1'b0);
      run(3'd6, 8'd12, 8'd10, 8'h78, 8'h00, 1'b0, 1'b0, 9, 0, 1'b1);
`else
      run(3'd6, 8'd12, 8'd10, 8'd0, 8'd0, 1'b0, 1'b1, 1, 0, 1'b0);
`endif
      run(3'd0, 8'd1, 8'd1, 8'd2, 8'd0, 1'b0, 1'b0, 2, 3, 1'b1);
      // reset while a result is waiting in DONE
      req_op = 3'd0; req_a = 8'd9; req_b = 8'd9; req_valid = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(posedge clk);
      #2;
      chk("done_valid", resp_valid, 1);
      chk("done_lo", res_lo, 18);
      rst = 1'b1;
      #1;
      chk("rstd_valid", resp_valid, 0);
      chk("rstd_ready", req_ready, 0);
      chk("rstd_lo", res_lo, 0);
      @(posedge clk);
      #2 rst = 1'b0;
      @(posedge clk);
      #1;
`ifdef ALU_SEQ_MUL_EN
      // reset during the fourth multiply cycle
      req_op = 3'd6; req_a = 8'h37; req_b = 8'h29; req_valid = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      chk("rstm_valid", resp_valid, 0);
      chk("rstm_ready", req_ready, 0);
      chk("rstm_alu", {alu_ctrl, alu_a, alu_b}, 0);
      chk("rstm_hi", res_hi, 0);
      @(posedge clk);
      #2 rst = 1'b0;
      @(posedge clk);
      #1;
`endif
      run(3'd0, 8'd3, 8'd4, 8'd7, 8'd0, 1'b0, 1'b0, 2, 0, 1'b0);
      repeat (2) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
